// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed hex seven-segment driver for NUM_DIGITS digits. It
//   scans one digit per slot of SLOT_CYCLES clocks. Each slot starts with
//   BLANK_CYCLES clocks of all anodes off, which stops ghosting while the
//   segment lines settle. New data is written to a shadow register and
//   copied to the display register only at the frame wrap, so a frame is
//   never torn.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   value      packed hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in      decimal point request per digit
//   load       one-cycle strobe, captures value/dp_in into the shadow register
//   lz_en      suppress leading zeros
//   enable     0 keeps the display dark while the scan keeps running
//   seg        segments {g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   dp         decimal point, polarity set by SEG_ACT_LOW
//   an         one-hot digit enable, polarity set by AN_ACT_LOW
//   frame_tick one-cycle pulse when the scan wraps from the last digit to digit 0
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  // The slot timer counts down. A remaining count of r is the same as an
  // elapsed count of SLOT_CYCLES-1-r, so the blank window is the top of
  // the remaining range.
  localparam logic [PW-1:0] SLOT_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] BLANK_TOP = PW'(SLOT_CYCLES - 1 - BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             slot_cnt;
  logic [IW-1:0]             digit_idx;
  logic [4*NUM_DIGITS-1:0]   shadow_val;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic [4*NUM_DIGITS-1:0]   disp_val;
  logic [NUM_DIGITS-1:0]     disp_dp;

  logic                      slot_tc;
  logic                      frame_wrap;
  logic                      in_blank;
  logic [3:0]                cur_nib;
  logic [NUM_DIGITS-1:0]     upper_zero;
  logic                      lz_blank;
  logic [6:0]                seg_hi;
  logic [NUM_DIGITS-1:0]     an_hi;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_tc    = (slot_cnt == '0);
  assign frame_wrap = slot_tc && (digit_idx == IDX_LAST);
  assign in_blank   = (slot_cnt > BLANK_TOP);
  assign cur_nib    = disp_val[{digit_idx, 2'b00} +: 4];

  // upper_zero[i] is set when digit i and every digit to its left are all zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ((disp_val >> (4 * i)) == '0);
    end
  end

  assign lz_blank = lz_en && (digit_idx != '0) && upper_zero[digit_idx];
  assign seg_hi   = lz_blank ? 7'h00 : hex_decode(cur_nib);
  assign an_hi    = (enable && !in_blank) ? (NUM_DIGITS'(1) << digit_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= SLOT_LAST;
      digit_idx  <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      slot_cnt <= slot_tc ? SLOT_LAST : slot_cnt - 1'b1;
      if (slot_tc) begin
        digit_idx <= frame_wrap ? '0 : digit_idx + 1'b1;
      end
      // On the wrap edge the display register takes the shadow value from
      // before this edge, so a load on the same edge appears one frame later.
      if (frame_wrap) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_ACT_LOW ? 7'h7F : 7'h00;
      dp         <= SEG_ACT_LOW;
      an         <= AN_ACT_LOW ? '1 : '0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= SEG_ACT_LOW ? ~seg_hi : seg_hi;
      dp         <= SEG_ACT_LOW ? ~disp_dp[digit_idx] : disp_dp[digit_idx];
      an         <= AN_ACT_LOW ? ~an_hi : an_hi;
      frame_tick <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  localparam int N     = 4;
  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = N * SLOT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]   dp_in = '0;
  logic           load = 1'b0;
  logic           lz_en = 1'b0;
  logic           enable = 1'b1;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_tick;

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .enable(enable), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Behavioural model: the scan position comes from the number of edges
  // since reset. Outputs after an edge describe the state before it.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int unsigned    t_m = 0;
  int             m_p, m_d;
  logic           m_blank;
  logic [4*N-1:0] sh_val_m = '0, disp_val_m = '0;
  logic [N-1:0]   sh_dp_m = '0, disp_dp_m = '0;
  logic [6:0]     exp_seg = 7'h7F;
  logic           exp_dp = 1'b1;
  logic [N-1:0]   exp_an = '1;
  logic           exp_ft = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_m = 0;
      sh_val_m = '0; sh_dp_m = '0; disp_val_m = '0; disp_dp_m = '0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1; exp_ft = 1'b0;
    end else begin
      m_p = int'(t_m % SLOT);
      m_d = int'((t_m / SLOT) % N);
      m_blank = lz_en && (m_d != 0) && ((disp_val_m >> (4 * m_d)) == 0);
      exp_seg = m_blank ? 7'h7F : ~seg_tab[4'(disp_val_m >> (4 * m_d))];
      exp_dp  = ~disp_dp_m[m_d];
      exp_an  = (enable && m_p >= BLANK) ? ~(N'(1) << m_d) : '1;
      exp_ft  = (m_p == SLOT - 1) && (m_d == N - 1);
      if (exp_ft) begin
        disp_val_m = sh_val_m;
        disp_dp_m  = sh_dp_m;
      end
      if (load) begin
        sh_val_m = value;
        sh_dp_m  = dp_in;
      end
      t_m++;
    end
  end

  always @(negedge clk) begin
    check("outputs", {19'd0, frame_tick, an, dp, seg}, {19'd0, exp_ft, exp_an, exp_dp, exp_seg});
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) return;
    end
    check("frame_tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_word(input logic [4*N-1:0] v, input logic [N-1:0] d);
    @(negedge clk);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [15:0] sweep_val [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
  logic [6:0]  sweep_d3  [4] = '{7'h40, 7'h19, 7'h00, 7'h46};
  logic [6:0]  sweep_d0  [4] = '{7'h30, 7'h78, 7'h03, 7'h0E};

  initial begin
    int cnt, act_cnt, tick_cnt;
    logic [4*N-1:0] rv;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-slot: outputs must go inactive without a clock edge.
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_ft", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep.
    for (int k = 0; k < 4; k++) begin
      load_word(sweep_val[k], '0);
      wait_frame();
      wait_frame();
      check("sweep_digit3_seg", seg, sweep_d3[k]);
      check("sweep_digit3_an", an, 4'h7);
      skip(3);
      check("sweep_digit0_seg", seg, sweep_d0[k]);
      check("sweep_digit0_an", an, 4'hE);
    end

    // Frame period and anode-active cycles per frame.
    wait_frame();
    cnt = 0;
    act_cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (an !== 4'hF) act_cnt++;
    end while (frame_tick !== 1'b1 && cnt < 100);
    check("frame_period", cnt, FRAME);
    check("an_active_cycles", act_cnt, 32);

    // Two loads within one frame: the rest of the frame keeps the old data.
    skip(5);
    load_word(16'h1111, '0);
    skip(5);
    load_word(16'h2222, '0);
    wait_frame();
    check("tear_old_frame", seg, 7'h46);
    skip(3);
    check("tear_new_frame", seg, 7'h24);

    // Load on the wrap edge itself.
    cnt = 0;
    while ((t_m % FRAME) != FRAME - 1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    value = 16'h3333; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("wrap_tick", frame_tick, 1'b1);
    skip(3);
    check("wrap_load_old", seg, 7'h24);
    wait_frame();
    skip(3);
    check("wrap_load_new", seg, 7'h30);

    // Leading-zero suppression.
    lz_en = 1'b1;
    load_word(16'h0050, 4'b1000);
    wait_frame();
    wait_frame();
    check("lz_digit3_seg", seg, 7'h7F);
    check("lz_digit3_dp", dp, 1'b0);
    skip(3);
    check("lz_digit0_seg", seg, 7'h40);
    check("lz_digit0_dp", dp, 1'b1);
    skip(10);
    check("lz_digit1_seg", seg, 7'h12);
    load_word(16'h0000, 4'b0000);
    wait_frame();
    wait_frame();
    check("lz_zero_digit3", seg, 7'h7F);
    skip(3);
    check("lz_zero_digit0", seg, 7'h40);

    // Display disabled for 1.5 frames.
    wait_frame();
    enable = 1'b0;
    tick_cnt = 0;
    act_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_tick === 1'b1) tick_cnt++;
      if (an !== 4'hF) act_cnt++;
    end
    check("disabled_ticks", tick_cnt, 1);
    check("disabled_an_active", act_cnt, 0);
    enable = 1'b1;
    lz_en = 1'b0;
    skip(FRAME);

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      load = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++)
          rv[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        value = rv;
        dp_in = N'($urandom);
        load = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
    end
    @(negedge clk);
    load = 1'b0;
    skip(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
